// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - guess-row sequencer: debounced peg entry, scoring handshake, score hold, win/lose
module round_sequencer #(
    parameter int DEBOUNCE_CYCLES = 15000000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int NUM_ROWS        = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tap_valid,
    input  logic [2:0]  i_tap_col,
    input  logic        i_score_ack,
    input  logic [2:0]  i_score_black,
    input  logic [2:0]  i_score_white,
    output logic [11:0] o_guess,
    output logic [2:0]  o_row,
    output logic        o_score_req,
    output logic [2:0]  o_black_out,
    output logic [2:0]  o_white_out,
    output logic [3:0]  o_col_led,
    output logic        o_next_round,
    output logic        o_game_won,
    output logic        o_game_lost
);

    localparam logic [24:0] DEB_LOAD  = 25'(DEBOUNCE_CYCLES);
    // Hold counter runs HOLD_LOAD..0, so SHOW lasts exactly HOLD_CYCLES cycles.
    localparam logic [24:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? 25'(HOLD_CYCLES - 1) : 25'd0;
    localparam logic [2:0]  ROW_TOP   = 3'(NUM_ROWS - 1);

    typedef enum logic [2:0] {S_EDIT, S_SCORE, S_SHOW, S_WON, S_LOST} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [24:0] r_deb;
    logic [24:0] r_hold;
    logic [11:0] r_guess;
    logic [2:0]  r_row;
    logic [2:0]  r_black;
    logic [2:0]  r_white;
    logic [3:0]  r_col_led;
    logic        r_next_round;

    logic        w_full;
    logic        w_tap_ok;
    logic        w_col_tap;
    logic        w_submit;
    logic        w_ack;
    logic        w_hold_done;
    logic [2:0]  w_field;
    logic [2:0]  w_field_nxt;
    logic [2:0]  w_black_clamp;
    logic [2:0]  w_white_lim;
    logic [2:0]  w_white_clamp;

    always_comb begin
        w_full        = (|r_guess[2:0]) && (|r_guess[5:3]) && (|r_guess[8:6]) && (|r_guess[11:9]);
        w_tap_ok      = (r_state == S_EDIT) && i_tap_valid && (r_deb == 25'd0);
        w_col_tap     = w_tap_ok && !i_tap_col[2];
        w_submit      = w_tap_ok && (i_tap_col == 3'd4) && w_full;
        w_ack         = (r_state == S_SCORE) && i_score_ack;
        w_hold_done   = (r_state == S_SHOW) && (r_hold == 25'd0);
        w_field       = r_guess[i_tap_col[1:0]*3 +: 3];
        w_field_nxt   = (w_field >= 3'd6) ? 3'd1 : w_field + 3'd1;
        w_black_clamp = (i_score_black > 3'd4) ? 3'd4 : i_score_black;
        w_white_lim   = 3'd4 - w_black_clamp;
        w_white_clamp = (i_score_white > w_white_lim) ? w_white_lim : i_score_white;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EDIT:  if (w_submit) w_state_nxt = S_SCORE;
            S_SCORE: if (w_ack) w_state_nxt = (w_black_clamp == 3'd4) ? S_WON : S_SHOW;
            S_SHOW:  if (w_hold_done) w_state_nxt = (r_row == 3'd0) ? S_LOST : S_EDIT;
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_EDIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_deb        <= '0;
            r_hold       <= '0;
            r_guess      <= '0;
            r_row        <= ROW_TOP;
            r_black      <= '0;
            r_white      <= '0;
            r_col_led    <= '0;
            r_next_round <= 1'b0;
        end else begin
            r_next_round <= 1'b0;

            // Opening a new row forces the debounce window closed so the first tap counts.
            if (w_col_tap || w_submit) begin
                r_deb <= DEB_LOAD;
            end else if (w_hold_done) begin
                r_deb <= '0;
            end else if (r_deb != 25'd0) begin
                r_deb <= r_deb - 25'd1;
            end

            if (w_col_tap) begin
                r_col_led                      <= 4'b0001 << i_tap_col[1:0];
                r_guess[i_tap_col[1:0]*3 +: 3] <= w_field_nxt;
            end

            if (w_ack) begin
                r_black <= w_black_clamp;
                r_white <= w_white_clamp;
                r_hold  <= HOLD_LOAD;
            end else if ((r_state == S_SHOW) && (r_hold != 25'd0)) begin
                r_hold <= r_hold - 25'd1;
            end

            if (w_hold_done && (r_row != 3'd0)) begin
                r_row        <= r_row - 3'd1;
                r_guess      <= '0;
                r_black      <= '0;
                r_white      <= '0;
                r_col_led    <= '0;
                r_next_round <= 1'b1;
            end
        end
    end

    assign o_guess      = r_guess;
    assign o_row        = r_row;
    assign o_score_req  = (r_state == S_SCORE);
    assign o_black_out  = r_black;
    assign o_white_out  = r_white;
    assign o_col_led    = r_col_led;
    assign o_next_round = r_next_round;
    assign o_game_won   = (r_state == S_WON);
    assign o_game_lost  = (r_state == S_LOST);

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - directed self-checking bench for round_sequencer
module tb_round_sequencer;

    logic        clk;
    logic        rst_n;
    logic        tap_valid;
    logic [2:0]  tap_col;
    logic        score_ack;
    logic [2:0]  score_black;
    logic [2:0]  score_white;
    logic [11:0] guess;
    logic [2:0]  row;
    logic        score_req;
    logic [2:0]  black_out;
    logic [2:0]  white_out;
    logic [3:0]  col_led;
    logic        next_round;
    logic        game_won;
    logic        game_lost;

    int total;
    int bad;

    round_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (8),
        .NUM_ROWS       (2)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tap_valid  (tap_valid),
        .i_tap_col    (tap_col),
        .i_score_ack  (score_ack),
        .i_score_black(score_black),
        .i_score_white(score_white),
        .o_guess      (guess),
        .o_row        (row),
        .o_score_req  (score_req),
        .o_black_out  (black_out),
        .o_white_out  (white_out),
        .o_col_led    (col_led),
        .o_next_round (next_round),
        .o_game_won   (game_won),
        .o_game_lost  (game_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic tap(input logic [2:0] c);
        tap_valid = 1'b1;
        tap_col   = c;
        tick();
        tap_valid = 1'b0;
        tap_col   = 3'd7;
    endtask

    task automatic fill_ones();
        for (int c = 0; c < 4; c++) begin
            tap(3'(c));
            idle(4);
        end
    endtask

    task automatic ack(input logic [2:0] b, input logic [2:0] w);
        score_ack   = 1'b1;
        score_black = b;
        score_white = w;
        tick();
        score_ack   = 1'b0;
        score_black = 3'd0;
        score_white = 3'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_guess"}, 32'(guess), 32'h0);
        check({tag, "_row"}, 32'(row), 32'd1);
        check({tag, "_req"}, 32'(score_req), 32'd0);
        check({tag, "_black"}, 32'(black_out), 32'd0);
        check({tag, "_white"}, 32'(white_out), 32'd0);
        check({tag, "_led"}, 32'(col_led), 32'd0);
        check({tag, "_nr"}, 32'(next_round), 32'd0);
        check({tag, "_won"}, 32'(game_won), 32'd0);
        check({tag, "_lost"}, 32'(game_lost), 32'd0);
    endtask

    initial begin
        int seq[7];
        int n;
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        tap_valid   = 1'b0;
        tap_col     = 3'd7;
        score_ack   = 1'b0;
        score_black = 3'd0;
        score_white = 3'd0;
        seq = '{1, 2, 3, 4, 5, 6, 1};

        idle(2);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 7; i++) begin
            tap(3'd0);
            check($sformatf("col0_step%0d", i), 32'(guess[2:0]), 32'(seq[i]));
            idle(4);
        end
        check("col0_led", 32'(col_led), 32'b0001);

        tap(3'd1);
        idle(1);
        tap(3'd1);
        check("deb_reject", 32'(guess[5:3]), 32'd1);
        check("deb_led", 32'(col_led), 32'b0010);
        idle(4);

        tap(3'd4);
        check("submit_incomplete_req", 32'(score_req), 32'd0);
        tap(3'd2);
        check("submit_no_reload", 32'(guess[8:6]), 32'd1);
        idle(4);
        tap(3'd6);
        tap(3'd3);
        check("nocol_no_reload", 32'(guess), 32'h249);
        check("col3_led", 32'(col_led), 32'b1000);
        idle(4);

        tap(3'd4);
        check("submit_req", 32'(score_req), 32'd1);
        idle(4);
        tap(3'd0);
        check("score_discard_tap", 32'(guess), 32'h249);
        check("score_req_held", 32'(score_req), 32'd1);
        ack(3'd1, 3'd5);
        check("ack_black", 32'(black_out), 32'd1);
        check("ack_white_clamp", 32'(white_out), 32'd3);
        check("ack_req_drop", 32'(score_req), 32'd0);

        n = 0;
        while (!next_round && n < 20) begin
            tick();
            n++;
        end
        check("hold_len", 32'(n), 32'd8);
        check("nr_row", 32'(row), 32'd0);
        check("nr_guess", 32'(guess), 32'h0);
        check("nr_black", 32'(black_out), 32'd0);
        check("nr_led", 32'(col_led), 32'd0);
        tap(3'd1);
        check("nr_deb_zero", 32'(guess[5:3]), 32'd1);
        check("nr_pulse_1cyc", 32'(next_round), 32'd0);
        idle(4);

        tap(3'd0); idle(4);
        tap(3'd2); idle(4);
        tap(3'd3); idle(4);
        tap(3'd4);
        check("row0_req", 32'(score_req), 32'd1);
        ack(3'd2, 3'd1);
        check("row0_black", 32'(black_out), 32'd2);
        check("row0_white", 32'(white_out), 32'd1);
        n = 0;
        while (!game_lost && n < 20) begin
            tick();
            n++;
        end
        check("lost_len", 32'(n), 32'd8);
        check("lost_flag", 32'(game_lost), 32'd1);
        check("lost_guess", 32'(guess), 32'h249);
        check("lost_black", 32'(black_out), 32'd2);
        tap(3'd0);
        idle(5);
        check("lost_tap_ignored", 32'(guess), 32'h249);
        check("lost_won_zero", 32'(game_won), 32'd0);

        do_reset();
        check_reset_outputs("rst2");
        fill_ones();
        tap(3'd4);
        check("mid_req", 32'(score_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_req_drop", 32'(score_req), 32'd0);
        idle(1);
        rst_n = 1'b1;
        ack(3'd3, 3'd1);
        check_reset_outputs("midrst");

        fill_ones();
        tap(3'd4);
        ack(3'd6, 3'd3);
        check("won_black_clamp", 32'(black_out), 32'd4);
        check("won_white_clamp", 32'(white_out), 32'd0);
        check("won_flag", 32'(game_won), 32'd1);
        check("won_req", 32'(score_req), 32'd0);
        tap(3'd2);
        idle(5);
        check("won_tap_ignored", 32'(guess), 32'h249);
        ack(3'd1, 3'd1);
        check("won_ack_ignored", 32'(black_out), 32'd4);
        check("won_lost_zero", 32'(game_lost), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
